// File: rtl/spu_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_lite_pkg
// Description : Shared types and constants for the SPU_Lite fetch front end.
//               INSTR_W / PAIR_W size the instruction words, IMEM_ADDR_W is
//               the byte-address width of the instruction memory, and
//               fetch_entry_t is one buffered instruction pair.
// Revision    : 1.0 - initial release
// ============================================================================
package spu_lite_pkg;

  localparam int INSTR_W     = 32;
  localparam int PAIR_W      = 64;
  localparam int IMEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [0:INSTR_W-1]     instr0;
    logic [0:INSTR_W-1]     instr1;
    logic [0:IMEM_ADDR_W-1] pc;
    logic                   slot0_vld;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/spu_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spu_fetch_fifo
// Description : Instruction-pair buffer holding fetch_entry_t records.
//               Push and pop may occur in the same cycle; clear empties the
//               buffer synchronously and takes priority over push/pop.
// Ports       : clk, reset (async, active-high), clear, push, push_data,
//               pop, head (entry at read pointer), count (occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module spu_fetch_fifo
  import spu_lite_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        push,
  input  fetch_entry_t                push_data,
  input  logic                        pop,
  output fetch_entry_t                head,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  fetch_entry_t  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  // Storage is not reset; validity is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/spu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spu_fetch_ctrl
// Description : SPU_Lite instruction-fetch sequencer. Issues 8-byte aligned
//               fetches to a 1-cycle-latency instruction memory, buffers the
//               returned pairs and hands them to issue via valid/ready.
//               Handles branch redirect (flush) and halt.
// Ports       : clk, reset (async, active-high)
//               imem_req/imem_addr/imem_rdata  - instruction memory side
//               pair_valid/pair_instr0/pair_instr1/pair_slot0_vld/pair_pc,
//               pair_ready                     - issue side
//               branch_taken/branch_target     - redirect
//               halt                           - stop fetching
// Options     : FETCH_STATS_EN adds fetch_stall_cnt, a saturating count of
//               RUN cycles in which fetch was blocked by buffer credit.
// Revision    : 1.0 - initial release
// ============================================================================
module spu_fetch_ctrl
  import spu_lite_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [0:ADDR_W-1] imem_addr,
  input  logic [0:PAIR_W-1] imem_rdata,
  output logic              pair_valid,
  output logic [0:INSTR_W-1] pair_instr0,
  output logic [0:INSTR_W-1] pair_instr1,
  output logic              pair_slot0_vld,
  output logic [0:ADDR_W-1] pair_pc,
  input  logic              pair_ready,
  input  logic              branch_taken,
  input  logic [0:ADDR_W-1] branch_target,
  input  logic              halt
`ifdef FETCH_STATS_EN
  ,
  output logic [0:31]       fetch_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic [0:ADDR_W-1] r_fetch_pc;
  logic [0:ADDR_W-1] r_resp_pc;
  logic              r_resp_slot0;
  logic              r_inflight;
  logic              r_odd_pending;

  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;
  logic [CW:0]       w_count;
  logic [CW+1:0]     w_need;
  logic              w_active;
  logic              w_branch;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_credit;
  logic              w_req;

  assign w_active = (r_state == RUN) || (r_state == FLUSH);
  assign w_branch = w_active && branch_taken;
  assign w_valid  = (w_count != '0);
  assign w_pop    = w_valid && pair_ready && !w_branch;
  // A response landing in FLUSH belongs to the abandoned stream.
  assign w_push   = r_inflight && !w_branch && (r_state != FLUSH);

  // Occupancy after this cycle if a new request were issued now; the pop
  // in this cycle frees its slot immediately.
  assign w_need   = (CW+2)'(w_count) + (CW+2)'(r_inflight) + (CW+2)'(1)
                  - (CW+2)'(w_pop);
  assign w_credit = (w_need <= (CW+2)'(FIFO_DEPTH));
  assign w_req    = w_active && !w_branch && !halt && w_credit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = RUN;
      RUN, FLUSH: begin
        if (halt)          w_next = HALT;
        else if (w_branch) w_next = r_inflight ? FLUSH : RUN;
        else               w_next = RUN;
      end
      HALT:       w_next = HALT;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_fetch_pc    <= '0;
      r_resp_pc     <= '0;
      r_resp_slot0  <= 1'b0;
      r_inflight    <= 1'b0;
      r_odd_pending <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_req;
      if (w_branch) begin
        r_fetch_pc    <= branch_target & ~ADDR_W'(7);
        r_odd_pending <= branch_target[ADDR_W-3];
      end else if (w_req) begin
        r_resp_pc     <= r_fetch_pc;
        r_resp_slot0  <= !r_odd_pending;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(8);
        r_odd_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_push_data           = '0;
    w_push_data.instr0    = imem_rdata[0:INSTR_W-1];
    w_push_data.instr1    = imem_rdata[INSTR_W:PAIR_W-1];
    w_push_data.pc        = IMEM_ADDR_W'(r_resp_pc);
    w_push_data.slot0_vld = r_resp_slot0;
  end

  spu_fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_branch),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  assign imem_req       = w_req;
  assign imem_addr      = w_req ? r_fetch_pc : '0;
  assign pair_valid     = w_valid;
  // Head fields are masked so stale storage never shows on the outputs.
  assign pair_instr0    = w_valid ? w_head.instr0 : '0;
  assign pair_instr1    = w_valid ? w_head.instr1 : '0;
  assign pair_slot0_vld = w_valid && w_head.slot0_vld;
  assign pair_pc        = w_valid ? ADDR_W'(w_head.pc) : '0;

`ifdef FETCH_STATS_EN
  logic [0:31] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && !w_branch && !halt && !w_credit
                 && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
